// File: rtl/mc_control_pkg.sv
// Shared definitions for the multi-cycle control sequencer: state encoding,
// opcodes and R-type func codes.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

package mc_control_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_ADI = 4'd4;
    localparam logic [3:0] OP_ORI = 4'd5;
    localparam logic [3:0] OP_LHI = 4'd6;
    localparam logic [3:0] OP_LWD = 4'd7;
    localparam logic [3:0] OP_SWD = 4'd8;
    localparam logic [3:0] OP_JMP = 4'd9;
    localparam logic [3:0] OP_R   = 4'd15;

    localparam logic [5:0] INST_FUNC_ADD = 6'd0;
    localparam logic [5:0] INST_FUNC_SUB = 6'd1;
    localparam logic [5:0] INST_FUNC_AND = 6'd2;
    localparam logic [5:0] INST_FUNC_ORR = 6'd3;
    localparam logic [5:0] INST_FUNC_NOT = 6'd4;
    localparam logic [5:0] INST_FUNC_TCP = 6'd5;
    localparam logic [5:0] INST_FUNC_SHL = 6'd6;
    localparam logic [5:0] INST_FUNC_SHR = 6'd7;
    localparam logic [5:0] INST_FUNC_WWD = 6'd28;
    localparam logic [5:0] INST_FUNC_HLT = 6'd29;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decode: IR to ALU controls, immediate extension,
// register selects and instruction class flags.
module mc_decode
    import mc_control_pkg::*;
#(
    parameter int WORD_SIZE = `WORD_SIZE
) (
    input  logic [WORD_SIZE-1:0] ir,
    output logic [5:0]           alu_func,
    output logic                 src_imm,
    output logic                 a_zero,
    output logic [WORD_SIZE-1:0] imm_ext,
    output logic [1:0]           rs_sel,
    output logic [1:0]           rt_sel,
    output logic [1:0]           reg_dst,
    output logic                 is_mem,
    output logic                 is_store,
    output logic                 is_halt,
    output logic                 is_jump,
    output logic                 is_out,
    output logic                 writes_reg
);

    logic [3:0] opcode;
    logic [5:0] func;
    logic [7:0] imm;

    assign opcode = ir[15:12];
    assign func   = ir[5:0];
    assign imm    = ir[7:0];
    assign rs_sel = ir[11:10];
    assign rt_sel = ir[9:8];

    always_comb begin
        alu_func   = INST_FUNC_ADD;
        src_imm    = 1'b0;
        a_zero     = 1'b0;
        imm_ext    = '0;
        reg_dst    = ir[9:8];
        is_mem     = 1'b0;
        is_store   = 1'b0;
        is_halt    = 1'b0;
        is_jump    = 1'b0;
        is_out     = 1'b0;
        writes_reg = 1'b0;
        case (opcode)
            OP_ADI: begin
                src_imm    = 1'b1;
                imm_ext    = {{(WORD_SIZE-8){imm[7]}}, imm};
                writes_reg = 1'b1;
            end
            OP_ORI: begin
                alu_func   = INST_FUNC_ORR;
                src_imm    = 1'b1;
                imm_ext    = {{(WORD_SIZE-8){1'b0}}, imm};
                writes_reg = 1'b1;
            end
            OP_LHI: begin
                src_imm    = 1'b1;
                a_zero     = 1'b1;
                imm_ext    = {imm, {(WORD_SIZE-8){1'b0}}};
                writes_reg = 1'b1;
            end
            OP_LWD: begin
                src_imm    = 1'b1;
                imm_ext    = {{(WORD_SIZE-8){imm[7]}}, imm};
                is_mem     = 1'b1;
                writes_reg = 1'b1;
            end
            OP_SWD: begin
                src_imm  = 1'b1;
                imm_ext  = {{(WORD_SIZE-8){imm[7]}}, imm};
                is_mem   = 1'b1;
                is_store = 1'b1;
            end
            OP_JMP: is_jump = 1'b1;
            OP_R: begin
                alu_func = func;
                reg_dst  = ir[7:6];
                // Funcs beyond the ALU range are specials or NOPs, never writes
                if (func <= INST_FUNC_SHR)      writes_reg = 1'b1;
                else if (func == INST_FUNC_WWD) is_out     = 1'b1;
                else if (func == INST_FUNC_HLT) is_halt    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control sequencer: fetch/decode/exec/mem/writeback FSM with
// registered datapath controls and a retired-instruction counter.
module mc_control
    import mc_control_pkg::*;
#(
    parameter int WORD_SIZE = `WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 fetch_req,
    input  logic                 fetch_ack,
    input  logic [WORD_SIZE-1:0] instr,
    output logic                 mem_req,
    output logic                 mem_we,
    input  logic                 mem_ack,
    output logic [5:0]           alu_func,
    output logic                 alu_src_imm,
    output logic                 alu_a_zero,
    output logic [WORD_SIZE-1:0] imm_ext,
    output logic [1:0]           rs_sel,
    output logic [1:0]           rt_sel,
    output logic                 reg_we,
    output logic [1:0]           reg_dst,
    output logic                 wb_mem,
    output logic                 pc_we,
    output logic                 pc_jump,
    output logic                 out_we,
    output logic                 halted,
    output logic [WORD_SIZE-1:0] num_inst
);

    state_t               state;
    logic [WORD_SIZE-1:0] ir;

    logic [5:0]           d_func;
    logic                 d_src_imm, d_a_zero;
    logic [WORD_SIZE-1:0] d_imm_ext;
    logic [1:0]           d_rs, d_rt, d_dst;
    logic                 d_is_mem, d_is_store, d_is_halt, d_is_jump, d_is_out, d_writes_reg;
    logic                 enter_wb;

    mc_decode #(.WORD_SIZE(WORD_SIZE)) u_decode (
        .ir         (ir),
        .alu_func   (d_func),
        .src_imm    (d_src_imm),
        .a_zero     (d_a_zero),
        .imm_ext    (d_imm_ext),
        .rs_sel     (d_rs),
        .rt_sel     (d_rt),
        .reg_dst    (d_dst),
        .is_mem     (d_is_mem),
        .is_store   (d_is_store),
        .is_halt    (d_is_halt),
        .is_jump    (d_is_jump),
        .is_out     (d_is_out),
        .writes_reg (d_writes_reg)
    );

    // Both paths into WB raise the writeback strobes for exactly the WB cycle
    assign enter_wb = (state == ST_EXEC && !d_is_halt && !d_is_mem) ||
                      (state == ST_MEM && mem_ack);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_FETCH;
            ir          <= '0;
            fetch_req   <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            alu_func    <= '0;
            alu_src_imm <= 1'b0;
            alu_a_zero  <= 1'b0;
            imm_ext     <= '0;
            rs_sel      <= '0;
            rt_sel      <= '0;
            reg_dst     <= '0;
            reg_we      <= 1'b0;
            wb_mem      <= 1'b0;
            pc_we       <= 1'b0;
            pc_jump     <= 1'b0;
            out_we      <= 1'b0;
            halted      <= 1'b0;
            num_inst    <= '0;
        end else begin
            pc_we   <= enter_wb;
            reg_we  <= enter_wb & d_writes_reg;
            wb_mem  <= enter_wb & d_is_mem & ~d_is_store;
            out_we  <= enter_wb & d_is_out;
            pc_jump <= enter_wb & d_is_jump;
            case (state)
                ST_FETCH: begin
                    // fetch_req is low only in the first cycle after reset, so
                    // an ack that arrives then is ignored
                    if (fetch_req && fetch_ack) begin
                        ir        <= instr;
                        fetch_req <= 1'b0;
                        state     <= ST_DECODE;
                    end else begin
                        fetch_req <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    alu_func    <= d_func;
                    alu_src_imm <= d_src_imm;
                    alu_a_zero  <= d_a_zero;
                    imm_ext     <= d_imm_ext;
                    rs_sel      <= d_rs;
                    rt_sel      <= d_rt;
                    reg_dst     <= d_dst;
                    state       <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (d_is_halt) begin
                        halted <= 1'b1;
                        state  <= ST_HALT;
                    end else if (d_is_mem) begin
                        mem_req <= 1'b1;
                        mem_we  <= d_is_store;
                        state   <= ST_MEM;
                    end else begin
                        state <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= ST_WB;
                    end
                end
                ST_WB: begin
                    num_inst  <= num_inst + 1'b1;
                    fetch_req <= 1'b1;
                    state     <= ST_FETCH;
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: a fetch responder pushes the expected
// writeback for each issued instruction, a monitor checks it at pc_we.
module tb_mc_control;

    typedef struct {
        logic [15:0] instr;
        int          delay;
        logic        reg_we;
        logic [1:0]  dst;
        logic        wb_mem;
        logic        pc_jump;
        logic        out_we;
        logic        mem_we;
        logic [5:0]  func;
        logic        src_imm;
        logic        a_zero;
        logic [15:0] imm;
        int          lat;
        int          memc;
    } exp_t;

    localparam int N = 11;

    logic        clk, reset;
    logic        fetch_req, fetch_ack, mem_req, mem_we, mem_ack;
    logic [15:0] instr, imm_ext, num_inst;
    logic [5:0]  alu_func;
    logic        alu_src_imm, alu_a_zero, reg_we, wb_mem, pc_we, pc_jump, out_we, halted;
    logic [1:0]  rs_sel, rt_sel, reg_dst;

    exp_t prog [N];
    exp_t sb [$];
    int   compared = 0;
    int   mismatched = 0;
    int   mem_delay = 0;

    mc_control #(.WORD_SIZE(16)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_ack(fetch_ack), .instr(instr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
        .alu_func(alu_func), .alu_src_imm(alu_src_imm), .alu_a_zero(alu_a_zero),
        .imm_ext(imm_ext), .rs_sel(rs_sel), .rt_sel(rt_sel),
        .reg_we(reg_we), .reg_dst(reg_dst), .wb_mem(wb_mem),
        .pc_we(pc_we), .pc_jump(pc_jump), .out_we(out_we),
        .halted(halted), .num_inst(num_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(logic [15:0] i, int d, logic rw, logic [1:0] dst, logic wm,
                                logic pj, logic ow, logic mw, logic [5:0] f, logic si,
                                logic az, logic [15:0] im, int lat, int mc);
        exp_t e;
        e.instr = i; e.delay = d; e.reg_we = rw; e.dst = dst; e.wb_mem = wm;
        e.pc_jump = pj; e.out_we = ow; e.mem_we = mw; e.func = f; e.src_imm = si;
        e.a_zero = az; e.imm = im; e.lat = lat; e.memc = mc;
        return e;
    endfunction

    // Fetch responder: fetch_ack tied high, instruction supplied while fetch_req is up
    initial begin
        int idx = 0;
        forever begin
            @(negedge clk);
            if (!reset && fetch_req) begin
                if (idx < N) begin
                    instr     = prog[idx].instr;
                    mem_delay = prog[idx].delay;
                    sb.push_back(prog[idx]);
                    idx++;
                end else begin
                    instr = 16'hF01D;
                end
            end
        end
    end

    // Data memory: acks after mem_delay wait cycles
    initial begin
        int wcnt = 0;
        mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && mem_req && !mem_ack) begin
                if (wcnt == mem_delay) begin
                    mem_ack = 1'b1;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                mem_ack = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Monitor
    initial begin
        int   cyc = 0, start = 0, memc = 0, retired = 0;
        logic prev_req = 1'b0, mw = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                prev_req = 1'b0; memc = 0; mw = 1'b0; retired = 0;
                continue;
            end
            if (fetch_req && !prev_req) start = cyc;
            prev_req = fetch_req;
            if (mem_req) begin
                memc++;
                mw = mw | mem_we;
            end
            if (pc_we) begin
                if (sb.size() == 0) begin
                    chk("unexpected_wb", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("reg_we[%h]", e.instr), reg_we, e.reg_we);
                    if (e.reg_we) chk($sformatf("reg_dst[%h]", e.instr), reg_dst, e.dst);
                    chk($sformatf("wb_mem[%h]", e.instr), wb_mem, e.wb_mem);
                    chk($sformatf("pc_jump[%h]", e.instr), pc_jump, e.pc_jump);
                    chk($sformatf("out_we[%h]", e.instr), out_we, e.out_we);
                    chk($sformatf("mem_we[%h]", e.instr), mw, e.mem_we);
                    chk($sformatf("mem_cycles[%h]", e.instr), memc, e.memc);
                    chk($sformatf("latency[%h]", e.instr), cyc - start + 1, e.lat);
                    chk($sformatf("src_imm[%h]", e.instr), alu_src_imm, e.src_imm);
                    chk($sformatf("a_zero[%h]", e.instr), alu_a_zero, e.a_zero);
                    if (e.src_imm || e.instr[15:12] == 4'hF)
                        chk($sformatf("alu_func[%h]", e.instr), alu_func, e.func);
                    if (e.src_imm) chk($sformatf("imm_ext[%h]", e.instr), imm_ext, e.imm);
                    chk($sformatf("num_inst[%h]", e.instr), num_inst, retired);
                end
                retired++;
                memc = 0;
                mw = 1'b0;
            end else begin
                chk("strobe_outside_wb", {reg_we, out_we}, 2'b00);
            end
        end
    end

    // Stimulus and top-level checks
    initial begin
        //                instr    dly rw dst wm pj ow mw func si az imm      lat mc
        prog[0]  = mk(16'hF180, 0, 1, 2, 0, 0, 0, 0, 6'd0,  0, 0, 16'h0000, 4, 0);
        prog[1]  = mk(16'h4605, 0, 1, 2, 0, 0, 0, 0, 6'd0,  1, 0, 16'h0005, 4, 0);
        prog[2]  = mk(16'h66F0, 0, 1, 2, 0, 0, 0, 0, 6'd0,  1, 1, 16'hF000, 4, 0);
        prog[3]  = mk(16'h5180, 0, 1, 1, 0, 0, 0, 0, 6'd3,  1, 0, 16'h0080, 4, 0);
        prog[4]  = mk(16'h7110, 3, 1, 1, 1, 0, 0, 0, 6'd0,  1, 0, 16'h0010, 8, 4);
        prog[5]  = mk(16'h82FF, 0, 0, 2, 0, 0, 0, 1, 6'd0,  1, 0, 16'hFFFF, 5, 1);
        prog[6]  = mk(16'h9123, 0, 0, 1, 0, 1, 0, 0, 6'd0,  0, 0, 16'h0000, 4, 0);
        prog[7]  = mk(16'hF01C, 0, 0, 0, 0, 0, 1, 0, 6'd28, 0, 0, 16'h0000, 4, 0);
        prog[8]  = mk(16'h2ABC, 0, 0, 2, 0, 0, 0, 0, 6'd0,  0, 0, 16'h0000, 4, 0);
        prog[9]  = mk(16'hF03F, 0, 0, 0, 0, 0, 0, 0, 6'd63, 0, 0, 16'h0000, 4, 0);
        prog[10] = mk(16'hF0C1, 0, 1, 3, 0, 0, 0, 0, 6'd1,  0, 0, 16'h0000, 4, 0);

        reset = 1'b1;
        fetch_ack = 1'b1;
        instr = 16'h0000;
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs_zero",
                {fetch_req, mem_req, mem_we, alu_func, alu_src_imm, alu_a_zero, imm_ext,
                 rs_sel, rt_sel, reg_we, reg_dst, wb_mem, pc_we, pc_jump, out_we, halted, num_inst},
                64'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("fetch_req_after_reset", fetch_req, 1'b1);

        for (int i = 0; i < 300 && !halted; i++) @(negedge clk);
        chk("halt_reached", halted, 1'b1);
        chk("scoreboard_drained", sb.size(), 0);
        chk("num_inst_at_halt", num_inst, 16'd11);

        repeat (20) begin
            @(negedge clk);
            chk("halt_hold", {halted, fetch_req, mem_req, pc_we, reg_we, out_we}, 6'b100000);
        end

        #2 reset = 1'b1;
        #1;
        chk("halt_reset_num_inst", num_inst, 16'd0);
        chk("halt_reset_halted", halted, 1'b0);
        chk("halt_reset_fetch_req", fetch_req, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("refetch_after_halt_reset", fetch_req, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control sequencer for the 16-bit core. It fetches an instruction word, decodes opcode and func, and drives the `func` select plus the operand, writeback and PC controls for the combinational ALU and register file. It is the producer side of the ALU func/operand interface and sits between instruction/data memory handshakes and the datapath.

## Interface
- `WORD_SIZE`, default 16: instruction and data width. Taken from the shared `WORD_SIZE` define.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `fetch_req` out 1: instruction fetch request.
- `fetch_ack` in 1: instruction word valid on `instr`.
- `instr` in WORD_SIZE: instruction word. Fields:
  - [15:12] opcode
  - [11:10] rs
  - [9:8] rt
  - [7:6] rd
  - [5:0] func
  - [7:0] imm
  - [11:0] target
- `mem_req` out 1: data memory access request.
- `mem_we` out 1: the access is a write (SWD).
- `mem_ack` in 1: data access complete.
- `alu_func` out 6: ALU operation code (ADD=0, SUB=1, AND=2, ORR=3, NOT=4, TCP=5, SHL=6, SHR=7).
- `alu_src_imm` out 1: ALU operand 2 is the extended immediate.
- `alu_a_zero` out 1: ALU operand 1 forced to 0.
- `imm_ext` out WORD_SIZE: extended immediate.
  - ADI/LWD/SWD: sign-extended.
  - ORI: zero-extended.
  - LHI: {imm, 8'h00}.
- `rs_sel`, `rt_sel` out 2 each: register read addresses.
- `reg_we` out 1: register write strobe.
- `reg_dst` out 2: register write address.
- `wb_mem` out 1: writeback data comes from memory rather than the ALU.
- `pc_we` out 1: PC update strobe.
- `pc_jump` out 1: next PC is {PC[15:12], target} rather than PC+1.
- `out_we` out 1: WWD output strobe.
- `halted` out 1: the core has executed HLT.
- `num_inst` out WORD_SIZE: count of retired instructions.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH
  - Hold `fetch_req`=1 until `fetch_ack`.
  - On the ack edge, latch `instr` into IR and go to DECODE.
- DECODE
  - Register `alu_func`, select and extend signals from IR.
  - Go to EXEC.
- EXEC: the ALU controls are stable.
  - LWD/SWD go to MEM.
  - HLT goes to HALT.
  - All other instructions go to WB.
- MEM
  - Hold `mem_req`=1; `mem_we`=1 for SWD.
  - On `mem_ack`, go to WB.
- WB
  - One-cycle `pc_we`=1.
  - `reg_we`=1 for R-ALU ops (`reg_dst`=rd), ADI, ORI, LHI and LWD (`reg_dst`=rt).
  - `wb_mem`=1 for LWD.
  - `out_we`=1 for WWD.
  - `pc_jump`=1 for JMP (opcode 9).
  - `num_inst` increments (wraps 16'hFFFF→0).
  - Go to FETCH.
- Decode map, by opcode:
  - R (15): `alu_func`=func.
  - ADI (4), LWD (7), SWD (8): ADD with `alu_src_imm`.
  - ORI (5): ORR with `alu_src_imm`.
  - LHI (6): ADD with `alu_a_zero` and `alu_src_imm`.
- Special funcs under opcode 15: WWD=28, HLT=29.
- Unknown opcode or func: treated as NOP. PC advances, no writes, and `num_inst` still counts.
- HALT is absorbing, with `halted`=1 and every strobe 0. Only `reset` exits it.

## Timing
- Reset values:
  - State = FETCH; IR = 0; `num_inst` = 0.
  - All strobes, `alu_func`, `imm_ext`, selects and `halted` = 0.
  - `fetch_req` rises in the first cycle after reset is released.
- Reset mid-operation aborts immediately: requests drop asynchronously and no partial writeback occurs.
- Latency with zero-wait acks, counted as cycles from the `fetch_req` rise:
  - ALU/imm/JMP/WWD: 4 cycles.
  - LWD/SWD: 5 cycles.
- Each wait cycle on `fetch_ack` or `mem_ack` adds exactly one cycle.
- Requests stay stable, and `mem_we` stays stable, while waiting.
- An ack arriving while the matching request is low is ignored.
- `reg_we`, `pc_we` and `out_we` are single-cycle pulses, asserted only in WB.

## Structure
- Shared package:
  - state encoding (3 bits)
  - opcode constants
  - `INST_FUNC_*` constants, including WWD/HLT
- A single sub-module, `mc_decode`, is natural. It is combinational: IR to ALU controls, immediate extension, register selects and the class flags (is_mem, is_store, is_halt, writes_reg). The FSM and counter stay in `mc_control`.

## Test plan
- Reset for 3 cycles, then release, with `fetch_ack` tied to 1:
  - During reset, all outputs are 0.
  - `fetch_req`=1 on the first cycle after release.
- `instr`=16'hF180 (ADD $2←$0+$1):
  - `alu_func`=0 in EXEC.
  - WB has `reg_we`=1, `reg_dst`=2, `pc_we`=1.
  - `num_inst`=1 after 4 cycles.
- `instr`=16'h4605 (ADI $2←$1+5): `alu_src_imm`=1, `imm_ext`=16'h0005, `reg_dst`=2. Then 16'h66F0 (LHI): `imm_ext`=16'hF000, `alu_a_zero`=1.
- `instr`=16'h7110 (LWD) with `mem_ack` delayed by 3 cycles:
  - `mem_req` is held for 4 cycles.
  - WB has `wb_mem`=1, `reg_dst`=1.
  - Total latency is 8 cycles.
- `instr`=16'h9123 (JMP): WB has `pc_jump`=1, `pc_we`=1 and `reg_we`=0.
- `instr`=16'hF01D (HLT):
  - `halted`=1 and stays 1; `fetch_req` stays 0 for 20 cycles.
  - Asserting `reset` mid-HALT returns to FETCH with `num_inst`=0.
